vproc_issue_queue: RTL and testbench
====================================

VPROC_ISSUE_QUEUE -- requirements
Module: vproc_issue_queue

Interface
REQ-001 SHALL have parameter XLEN, default 64, scalar register width (32 or 64).
REQ-002 SHALL have parameter TID_W, default 3, transaction ID width.
REQ-003 SHALL have parameter IQ_DEPTH, default 4, issue queue entries (power of two, >=2).
REQ-004 SHALL have parameter RQ_DEPTH, default 4, max outstanding result-wait entries (power of two, >=2).
REQ-005 SHALL have port clk_i, in, 1, clock; reset rst_ni, asynchronous, active-low.
REQ-006 SHALL have port flush_i, in, 1, discard all issue-queue entries not yet granted.
REQ-007 SHALL have port issue_valid_i, in, 1, upstream instruction valid.
REQ-008 SHALL have port issue_ready_o, out, 1, issue queue can accept.
REQ-009 SHALL have port issue_tid_i, in, TID_W, transaction ID.
REQ-010 SHALL have port issue_instr_i, in, 32, instruction word.
REQ-011 SHALL have port issue_rs1_i, in, XLEN, scalar operand 1.
REQ-012 SHALL have port issue_rs2_i, in, XLEN, scalar operand 2.
REQ-013 SHALL have port vcore_valid_o, in the out direction, 1, head offered to vector core.
REQ-014 SHALL have port vcore_instr_o, out, 32, head instruction.
REQ-015 SHALL have port vcore_rs1_o, out, 32, head rs1[31:0].
REQ-016 SHALL have port vcore_rs2_o, out, 32, head rs2[31:0].
REQ-017 SHALL have port vcore_gnt_i, in, 1, core accepts head this cycle.
REQ-018 SHALL have port vcore_illegal_i, in, 1, granted instruction illegal (qualified by gnt).
REQ-019 SHALL have port vcore_xreg_wait_i, in, 1, granted instruction will return a scalar result.
REQ-020 SHALL have port vcore_xreg_valid_i, in, 1, scalar result returned (in grant order).
REQ-021 SHALL have port vcore_xreg_i, in, 32, scalar result.
REQ-022 SHALL have port res_valid_o, out, 1, completion pulse to writeback (no backpressure).
REQ-023 SHALL have port res_tid_o, out, TID_W, completing transaction ID.
REQ-024 SHALL have port res_data_o, out, XLEN, result, sign-extended from 32 bits.
REQ-025 SHALL have port res_exc_o, out, 1, completion is an illegal-instruction exception.
REQ-026 SHALL have port busy_o, out, 1, any entry in issue queue, result queue or skid.

Function
REQ-027 Issue queue SHALL be a FIFO of {tid, instr, rs1[31:0], rs2[31:0]}; push on issue_valid_i & issue_ready_o; issue_ready_o = ~full, from registered state only.
REQ-028 vcore_valid_o SHALL = ~iq_empty & ~rq_full & ~skid_valid & ~flush_i; head fields driven whenever non-empty.
REQ-029 Grant (vcore_valid_o & vcore_gnt_i) SHALL pop head; push to full queue while popping in the same cycle SHALL succeed only if issue_ready_o was high.
REQ-030 Grant with vcore_xreg_wait_i & ~vcore_illegal_i SHALL push head tid into result-wait FIFO; no completion at grant.
REQ-031 Grant otherwise SHALL create a grant completion: data 0, exc = vcore_illegal_i; illegal SHALL never push into result-wait FIFO.
REQ-032 vcore_xreg_valid_i with result-wait FIFO non-empty SHALL pop it and create an xreg completion with that tid and sign-extended vcore_xreg_i, exc 0; vcore_xreg_valid_i when empty SHALL be ignored.
REQ-033 All res_* outputs SHALL be registered: completion created in cycle N appears for exactly one cycle at N+1.
REQ-034 Simultaneous grant and xreg completion: xreg completion SHALL win; grant completion SHALL enter the 1-entry skid.
REQ-035 Skid SHALL be emitted in the first cycle with no xreg completion; while skid is valid, no new grant is possible (REQ-028).
REQ-036 flush_i SHALL empty the issue queue next cycle; result-wait FIFO, skid and pending res_* SHALL be unaffected; same-cycle push is dropped.
REQ-037 Result-wait push and pop in the same cycle SHALL keep the count unchanged, including when full.

Reset
REQ-038 On rst_ni low: both FIFOs empty, skid invalid, res_valid_o=0, res_tid_o=0, res_data_o=0, res_exc_o=0, busy_o=0; issue_ready_o=1 and vcore_valid_o=0 while in reset and after release.

Verification
REQ-039 Push tid 2, wait=0, gnt next cycle -> res_valid_o one cycle later with tid 2, data 0, exc 0.
REQ-040 Push tid 5, gnt with wait=1; 3 cycles later xreg_valid with 0x8000_0001 -> res tid 5, data 0xFFFF_FFFF_8000_0001 (XLEN=64).
REQ-041 Fill IQ_DEPTH=4 with gnt=0 -> issue_ready_o=0 after 4th push; 5th is not accepted; one gnt -> ready returns.
REQ-042 4 waiting grants (RQ full) -> vcore_valid_o=0; xreg return frees a slot -> vcore_valid_o=1 next cycle.
REQ-043 Same cycle: no-wait grant tid 1 and xreg return for tid 0 -> res tid 0 then tid 1 on consecutive cycles.
REQ-044 Illegal grant with wait=1 -> res exc=1, tid correct, RQ count unchanged; flush with 3 queued -> busy_o=0 next cycle if RQ empty.

Source files
------------

// File: rtl/vproc_issue_queue.sv
// Issue queue between the scalar core and the vector core. Holds pending instructions,
// tracks grants that still owe a scalar result, and returns one registered completion per cycle.
module vproc_issue_queue #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned TID_W    = 3,
    parameter int unsigned IQ_DEPTH = 4,
    parameter int unsigned RQ_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [TID_W-1:0] issue_tid_i,
    input  logic [31:0]      issue_instr_i,
    input  logic [XLEN-1:0]  issue_rs1_i,
    input  logic [XLEN-1:0]  issue_rs2_i,
    output logic             vcore_valid_o,
    output logic [31:0]      vcore_instr_o,
    output logic [31:0]      vcore_rs1_o,
    output logic [31:0]      vcore_rs2_o,
    input  logic             vcore_gnt_i,
    input  logic             vcore_illegal_i,
    input  logic             vcore_xreg_wait_i,
    input  logic             vcore_xreg_valid_i,
    input  logic [31:0]      vcore_xreg_i,
    output logic             res_valid_o,
    output logic [TID_W-1:0] res_tid_o,
    output logic [XLEN-1:0]  res_data_o,
    output logic             res_exc_o,
    output logic             busy_o
);

    localparam int unsigned IQ_AW = $clog2(IQ_DEPTH);
    localparam int unsigned RQ_AW = $clog2(RQ_DEPTH);
    localparam logic [IQ_AW:0] IQ_PTR_ONE = 1;
    localparam logic [RQ_AW:0] RQ_PTR_ONE = 1;

    // Handshakes: a transfer happens in a cycle where valid and ready (or gnt) are both high;
    // valid never depends combinationally on ready/gnt, and issue_ready_o comes from registers only.

    logic [TID_W-1:0] r_iq_tid   [IQ_DEPTH];
    logic [31:0]      r_iq_instr [IQ_DEPTH];
    logic [31:0]      r_iq_rs1   [IQ_DEPTH];
    logic [31:0]      r_iq_rs2   [IQ_DEPTH];
    logic [IQ_AW:0]   r_iq_wptr, r_iq_rptr;

    logic [TID_W-1:0] r_rq_tid [RQ_DEPTH];
    logic [RQ_AW:0]   r_rq_wptr, r_rq_rptr;

    logic             r_skid_valid;
    logic [TID_W-1:0] r_skid_tid;
    logic             r_skid_exc;

    logic             w_iq_empty, w_iq_full, w_rq_empty, w_rq_full;
    logic             w_iq_push, w_grant, w_rq_push, w_rq_pop, w_grant_cmp;
    logic [TID_W-1:0] w_head_tid;
    logic [XLEN-1:0]  w_xreg_sext;

    assign w_iq_empty = (r_iq_wptr == r_iq_rptr);
    assign w_iq_full  = (r_iq_wptr[IQ_AW] != r_iq_rptr[IQ_AW]) &&
                        (r_iq_wptr[IQ_AW-1:0] == r_iq_rptr[IQ_AW-1:0]);
    assign w_rq_empty = (r_rq_wptr == r_rq_rptr);
    assign w_rq_full  = (r_rq_wptr[RQ_AW] != r_rq_rptr[RQ_AW]) &&
                        (r_rq_wptr[RQ_AW-1:0] == r_rq_rptr[RQ_AW-1:0]);

    assign issue_ready_o = ~w_iq_full;
    assign w_iq_push     = issue_valid_i & issue_ready_o & ~flush_i;

    assign vcore_valid_o = ~w_iq_empty & ~w_rq_full & ~r_skid_valid & ~flush_i;
    assign vcore_instr_o = r_iq_instr[r_iq_rptr[IQ_AW-1:0]];
    assign vcore_rs1_o   = r_iq_rs1[r_iq_rptr[IQ_AW-1:0]];
    assign vcore_rs2_o   = r_iq_rs2[r_iq_rptr[IQ_AW-1:0]];
    assign w_head_tid    = r_iq_tid[r_iq_rptr[IQ_AW-1:0]];

    // Illegal instructions complete at grant even if the core claimed a pending result.
    assign w_grant     = vcore_valid_o & vcore_gnt_i;
    assign w_rq_push   = w_grant & vcore_xreg_wait_i & ~vcore_illegal_i;
    assign w_grant_cmp = w_grant & ~w_rq_push;
    assign w_rq_pop    = vcore_xreg_valid_i & ~w_rq_empty;
    assign w_xreg_sext = XLEN'($signed(vcore_xreg_i));

    assign busy_o = ~w_iq_empty | ~w_rq_empty | r_skid_valid;

    always_ff @(posedge clk_i) begin
        if (w_iq_push) begin
            r_iq_tid[r_iq_wptr[IQ_AW-1:0]]   <= issue_tid_i;
            r_iq_instr[r_iq_wptr[IQ_AW-1:0]] <= issue_instr_i;
            r_iq_rs1[r_iq_wptr[IQ_AW-1:0]]   <= issue_rs1_i[31:0];
            r_iq_rs2[r_iq_wptr[IQ_AW-1:0]]   <= issue_rs2_i[31:0];
        end
        if (w_rq_push) begin
            r_rq_tid[r_rq_wptr[RQ_AW-1:0]] <= w_head_tid;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_iq_wptr <= '0;
            r_iq_rptr <= '0;
        end else if (flush_i) begin
            r_iq_wptr <= '0;
            r_iq_rptr <= '0;
        end else begin
            if (w_iq_push) r_iq_wptr <= r_iq_wptr + IQ_PTR_ONE;
            if (w_grant)   r_iq_rptr <= r_iq_rptr + IQ_PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rq_wptr <= '0;
            r_rq_rptr <= '0;
        end else begin
            if (w_rq_push) r_rq_wptr <= r_rq_wptr + RQ_PTR_ONE;
            if (w_rq_pop)  r_rq_rptr <= r_rq_rptr + RQ_PTR_ONE;
        end
    end

    // Xreg completions take the output slot first; a colliding grant completion waits in the skid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_skid_valid <= 1'b0;
            r_skid_tid   <= '0;
            r_skid_exc   <= 1'b0;
            res_valid_o  <= 1'b0;
            res_tid_o    <= '0;
            res_data_o   <= '0;
            res_exc_o    <= 1'b0;
        end else begin
            res_valid_o <= w_rq_pop | r_skid_valid | w_grant_cmp;
            if (w_rq_pop) begin
                res_tid_o  <= r_rq_tid[r_rq_rptr[RQ_AW-1:0]];
                res_data_o <= w_xreg_sext;
                res_exc_o  <= 1'b0;
                if (w_grant_cmp) begin
                    r_skid_valid <= 1'b1;
                    r_skid_tid   <= w_head_tid;
                    r_skid_exc   <= vcore_illegal_i;
                end
            end else if (r_skid_valid) begin
                res_tid_o    <= r_skid_tid;
                res_data_o   <= '0;
                res_exc_o    <= r_skid_exc;
                r_skid_valid <= 1'b0;
            end else if (w_grant_cmp) begin
                res_tid_o  <= w_head_tid;
                res_data_o <= '0;
                res_exc_o  <= vcore_illegal_i;
            end
        end
    end

endmodule

// File: tb/tb_vproc_issue_queue.sv
// Self-checking bench for vproc_issue_queue: directed scenarios plus a short random mix,
// with completions checked in order against an expected queue.
module tb_vproc_issue_queue;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned TID_W = 3;
    localparam int unsigned EW    = TID_W + XLEN + 1;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [TID_W-1:0] issue_tid_i;
    logic [31:0]      issue_instr_i;
    logic [XLEN-1:0]  issue_rs1_i;
    logic [XLEN-1:0]  issue_rs2_i;
    logic             vcore_valid_o;
    logic [31:0]      vcore_instr_o;
    logic [31:0]      vcore_rs1_o;
    logic [31:0]      vcore_rs2_o;
    logic             vcore_gnt_i;
    logic             vcore_illegal_i;
    logic             vcore_xreg_wait_i;
    logic             vcore_xreg_valid_i;
    logic [31:0]      vcore_xreg_i;
    logic             res_valid_o;
    logic [TID_W-1:0] res_tid_o;
    logic [XLEN-1:0]  res_data_o;
    logic             res_exc_o;
    logic             busy_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0]    exp_q[$];
    logic [TID_W-1:0] iq_tid_q[$];
    logic [95:0]      iq_op_q[$];
    logic [TID_W-1:0] rq_q[$];
    logic [EW-1:0]    mon_e;

    vproc_issue_queue #(.XLEN(XLEN), .TID_W(TID_W), .IQ_DEPTH(4), .RQ_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_tid_i(issue_tid_i), .issue_instr_i(issue_instr_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .vcore_valid_o(vcore_valid_o), .vcore_instr_o(vcore_instr_o),
        .vcore_rs1_o(vcore_rs1_o), .vcore_rs2_o(vcore_rs2_o),
        .vcore_gnt_i(vcore_gnt_i), .vcore_illegal_i(vcore_illegal_i),
        .vcore_xreg_wait_i(vcore_xreg_wait_i), .vcore_xreg_valid_i(vcore_xreg_valid_i),
        .vcore_xreg_i(vcore_xreg_i),
        .res_valid_o(res_valid_o), .res_tid_o(res_tid_o), .res_data_o(res_data_o),
        .res_exc_o(res_exc_o), .busy_o(busy_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [TID_W-1:0] t, input logic [XLEN-1:0] d,
                                         input logic e);
        return {t, d, e};
    endfunction

    function automatic logic [XLEN-1:0] sext(input logic [31:0] d);
        return {{(XLEN-32){d[31]}}, d};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // driver tasks
    task automatic push(input logic [TID_W-1:0] t);
        logic [31:0] ins, a, b;
        ins = 32'hA000_0000 | 32'(t) | ($urandom_range(0, 255) << 8);
        a = $urandom;
        b = $urandom;
        check("push_ready", issue_ready_o, 1'b1);
        issue_valid_i = 1'b1;
        issue_tid_i   = t;
        issue_instr_i = ins;
        issue_rs1_i   = {32'($urandom), a};
        issue_rs2_i   = {32'($urandom), b};
        iq_tid_q.push_back(t);
        iq_op_q.push_back({ins, a, b});
        step();
        issue_valid_i = 1'b0;
    endtask

    task automatic grant(input logic w, input logic ill);
        logic [TID_W-1:0] t;
        logic [95:0] op;
        t  = iq_tid_q.pop_front();
        op = iq_op_q.pop_front();
        check("gnt_valid", vcore_valid_o, 1'b1);
        check("gnt_head", {vcore_instr_o, vcore_rs1_o, vcore_rs2_o}, op);
        vcore_gnt_i       = 1'b1;
        vcore_xreg_wait_i = w;
        vcore_illegal_i   = ill;
        if (w && !ill) rq_q.push_back(t);
        else exp_q.push_back(mk(t, '0, ill));
        step();
        vcore_gnt_i       = 1'b0;
        vcore_xreg_wait_i = 1'b0;
        vcore_illegal_i   = 1'b0;
    endtask

    task automatic xret(input logic [31:0] d);
        vcore_xreg_valid_i = 1'b1;
        vcore_xreg_i       = d;
        if (rq_q.size() > 0) exp_q.push_back(mk(rq_q.pop_front(), sext(d), 1'b0));
        step();
        vcore_xreg_valid_i = 1'b0;
    endtask

    // scoreboard
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && res_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("res_unexpected", res_valid_o, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("res", {res_tid_o, res_data_o, res_exc_o}, mon_e);
            end
        end
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; issue_tid_i = '0;
        issue_instr_i = '0; issue_rs1_i = '0; issue_rs2_i = '0; vcore_gnt_i = 1'b0;
        vcore_illegal_i = 1'b0; vcore_xreg_wait_i = 1'b0; vcore_xreg_valid_i = 1'b0;
        vcore_xreg_i = '0;
        #12;
        check("rst_ready", issue_ready_o, 1'b1);
        check("rst_vvalid", vcore_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_res", {res_valid_o, res_tid_o, res_data_o, res_exc_o}, '0);
        step();
        rst_ni = 1'b1;
        step();
        check("post_rst_ready", issue_ready_o, 1'b1);
        check("post_rst_vvalid", vcore_valid_o, 1'b0);

        // stray xreg return with nothing waiting must be ignored
        xret(32'h1234_5678);

        // simple no-wait grant
        push(3'd2);
        grant(1'b0, 1'b0);
        step();

        // waiting grant, result sign-extended
        push(3'd5);
        grant(1'b1, 1'b0);
        check("wait_busy", busy_o, 1'b1);
        repeat (2) step();
        vcore_xreg_valid_i = 1'b1;
        vcore_xreg_i = 32'h8000_0001;
        exp_q.push_back(mk(rq_q.pop_front(), 64'hFFFF_FFFF_8000_0001, 1'b0));
        step();
        vcore_xreg_valid_i = 1'b0;
        step();

        // fill the issue queue; 5th push and a push during the freeing grant are dropped
        for (int i = 0; i < 4; i++) push(TID_W'(i));
        check("full_ready", issue_ready_o, 1'b0);
        issue_valid_i = 1'b1;
        issue_tid_i   = 3'd7;
        step();
        check("full_ready_hold", issue_ready_o, 1'b0);
        grant(1'b0, 1'b0);
        issue_valid_i = 1'b0;
        check("ready_back", issue_ready_o, 1'b1);
        for (int i = 0; i < 3; i++) grant(1'b0, 1'b0);
        check("dropped_push", vcore_valid_o, 1'b0);
        step();

        // four waiting grants fill the result-wait FIFO and block further grants
        for (int i = 0; i < 4; i++) begin
            push(TID_W'(i));
            grant(1'b1, 1'b0);
        end
        push(3'd4);
        check("rq_full_block", vcore_valid_o, 1'b0);
        xret($urandom);
        check("rq_slot_free", vcore_valid_o, 1'b1);
        grant(1'b0, 1'b0);
        while (rq_q.size() > 0) xret($urandom);
        step();

        // grant completion colliding with an xreg completion goes through the skid
        push(3'd0);
        grant(1'b1, 1'b0);
        push(3'd1);
        vcore_gnt_i = 1'b1;
        vcore_xreg_valid_i = 1'b1;
        vcore_xreg_i = 32'h0000_00AB;
        check("coll_vvalid", vcore_valid_o, 1'b1);
        exp_q.push_back(mk(rq_q.pop_front(), 64'hAB, 1'b0));
        exp_q.push_back(mk(iq_tid_q.pop_front(), '0, 1'b0));
        void'(iq_op_q.pop_front());
        step();
        vcore_gnt_i = 1'b0;
        vcore_xreg_valid_i = 1'b0;
        check("coll_first", {res_valid_o, res_tid_o}, {1'b1, 3'd0});
        check("coll_skid_busy", busy_o, 1'b1);
        step();
        check("coll_second", {res_valid_o, res_tid_o}, {1'b1, 3'd1});
        step();

        // result-wait push and pop in the same cycle keep the count
        push(3'd2);
        grant(1'b1, 1'b0);
        push(3'd3);
        vcore_xreg_valid_i = 1'b1;
        vcore_xreg_i = 32'hFFFF_FFFE;
        exp_q.push_back(mk(rq_q.pop_front(), sext(32'hFFFF_FFFE), 1'b0));
        grant(1'b1, 1'b0);
        vcore_xreg_valid_i = 1'b0;
        check("rq_pp_busy", busy_o, 1'b1);
        xret(32'h7FFF_FFFF);
        check("rq_pp_empty", busy_o, 1'b0);

        // illegal grant with wait=1 completes with exception and never waits
        push(3'd6);
        grant(1'b1, 1'b1);
        check("illegal_busy", busy_o, 1'b0);

        // flush with three queued entries, same-cycle push dropped
        for (int i = 1; i < 4; i++) push(TID_W'(i));
        flush_i = 1'b1;
        issue_valid_i = 1'b1;
        issue_tid_i = 3'd7;
        #1;
        check("flush_vvalid", vcore_valid_o, 1'b0);
        step();
        flush_i = 1'b0;
        issue_valid_i = 1'b0;
        iq_tid_q.delete();
        iq_op_q.delete();
        check("flush_busy", busy_o, 1'b0);
        check("flush_vvalid_after", vcore_valid_o, 1'b0);
        check("flush_ready", issue_ready_o, 1'b1);

        // random mix
        for (int i = 0; i < 30; i++) begin
            push(TID_W'($urandom_range(0, 7)));
            if (rq_q.size() == 4) xret($urandom);
            grant(1'(($urandom_range(0, 1))), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1 && rq_q.size() > 0) xret($urandom);
            repeat ($urandom_range(0, 2)) step();
        end
        while (rq_q.size() > 0) xret($urandom);
        repeat (3) step();
        check("final_busy", busy_o, 1'b0);
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
